// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - multi-way RS issue selector with NP throttling and registered issue ports
module rs_issue_select #(
    parameter int                  RS_SIZE  = 16,
    parameter int                  ISSUE_W  = 2,
    parameter int                  FU_TYPES = 4,
    parameter int                  FU_TW    = 2,
    parameter int                  RR_MODE  = 0,
    parameter logic [FU_TYPES-1:0] NP_MASK  = 4'b1000,
    parameter int                  BUSY_CYC = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [RS_SIZE-1:0]                  req,
    input  logic [RS_SIZE*FU_TW-1:0]            func_in,
    input  logic                                stall,
    output logic [RS_SIZE-1:0]                  gnt,
    output logic [ISSUE_W-1:0]                  issue_valid,
    output logic [ISSUE_W*$clog2(RS_SIZE)-1:0]  issue_idx,
    output logic [ISSUE_W*FU_TW-1:0]            issue_func
);
    localparam int IW = $clog2(RS_SIZE);
    localparam int BW = $clog2(BUSY_CYC + 1);

    logic [IW-1:0]          ptr;
    logic [IW-1:0]          next_ptr;
    logic [BW-1:0]          busy [FU_TYPES];
    logic [RS_SIZE-1:0]     elig;
    logic [RS_SIZE-1:0]     taken;
    logic [FU_TYPES-1:0]    np_used;
    logic [ISSUE_W-1:0]     sel_valid;
    logic [ISSUE_W*IW-1:0]  sel_idx;
    logic [ISSUE_W*FU_TW-1:0] sel_func;

    // A slot is eligible when ready and its FU type is not a busy non-pipelined unit
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            elig[i] = req[i] & ~(NP_MASK[func_in[i*FU_TW +: FU_TW]]
                                 & (busy[func_in[i*FU_TW +: FU_TW]] != '0));
        end
    end

    // Fill issue ports in order, each taking the first untaken eligible slot from ptr
    always_comb begin : sel_p
        logic                 found;
        logic [IW-1:0]        slot;
        logic [FU_TW-1:0]     f;
        taken     = '0;
        np_used   = '0;
        sel_valid = '0;
        sel_idx   = '0;
        sel_func  = '0;
        found     = 1'b0;
        slot      = '0;
        f         = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            found = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                slot = ptr + IW'(j);
                f    = func_in[slot*FU_TW +: FU_TW];
                if (!found && elig[slot] && !taken[slot] && !(NP_MASK[f] && np_used[f])) begin
                    found                     = 1'b1;
                    taken[slot]               = 1'b1;
                    sel_valid[k]              = 1'b1;
                    sel_idx[k*IW +: IW]       = slot;
                    sel_func[k*FU_TW +: FU_TW] = f;
                    if (NP_MASK[f]) begin
                        np_used[f] = 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin start moves just past the slot taken by the highest valid port
    always_comb begin
        next_ptr = ptr;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (sel_valid[k]) begin
                next_ptr = sel_idx[k*IW +: IW] + IW'(1);
            end
        end
    end

    assign gnt = (stall || !reset_n) ? '0 : taken;

    // Issue-stage registers and scan pointer, frozen while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid <= '0;
            issue_idx   <= '0;
            issue_func  <= '0;
            ptr         <= '0;
        end else if (!stall) begin
            issue_valid <= sel_valid;
            issue_idx   <= sel_idx;
            issue_func  <= sel_func;
            if (RR_MODE != 0 && |sel_valid) begin
                ptr <= next_ptr;
            end
        end
    end

    // Non-pipelined busy counters: reload on an accepted grant, otherwise count down
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < FU_TYPES; t++) begin
                busy[t] <= '0;
            end
        end else begin
            for (int t = 0; t < FU_TYPES; t++) begin
                if (NP_MASK[t] && !stall && np_used[t]) begin
                    busy[t] <= BW'(BUSY_CYC - 1);
                end else if (busy[t] != '0) begin
                    busy[t] <= busy[t] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - scoreboard bench for rs_issue_select (fixed and round-robin instances)
module tb_rs_issue_select;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  req;
    logic [15:0] func_in;
    logic        stall;
    logic [7:0]  gnt0, gnt1;
    logic [1:0]  iv0, iv1;
    logic [5:0]  ii0, ii1;
    logic [3:0]  if0, if1;

    int cmp = 0;
    int err = 0;
    logic mon_en = 1'b0;

    logic [3:0]  npm = 4'b1000;
    int          pm [2];
    longint      rdy [2][4];
    longint      cyc = 0;
    logic [7:0]  gq0 [$];
    logic [7:0]  gq1 [$];
    logic [11:0] iq0 [$];
    logic [11:0] iq1 [$];
    logic [11:0] cur0 = '0;
    logic [11:0] cur1 = '0;

    rs_issue_select #(.RS_SIZE(8), .ISSUE_W(2), .FU_TYPES(4), .FU_TW(2), .RR_MODE(0),
                      .NP_MASK(4'b1000), .BUSY_CYC(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .req(req), .func_in(func_in), .stall(stall),
        .gnt(gnt0), .issue_valid(iv0), .issue_idx(ii0), .issue_func(if0));

    rs_issue_select #(.RS_SIZE(8), .ISSUE_W(2), .FU_TYPES(4), .FU_TW(2), .RR_MODE(1),
                      .NP_MASK(4'b1000), .BUSY_CYC(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .req(req), .func_in(func_in), .stall(stall),
        .gnt(gnt1), .issue_valid(iv1), .issue_idx(ii1), .issue_func(if1));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: walk slots in rotated order, hand them to ports until both are filled
    function automatic void pick(input int p, input logic [7:0] r, input logic [15:0] fi,
                                 input logic [3:0] blocked, output logic [7:0] g,
                                 output logic [1:0] v, output logic [5:0] ix, output logic [3:0] fn);
        int n;
        logic [3:0] used;
        g = '0; v = '0; ix = '0; fn = '0; n = 0; used = '0;
        for (int j = 0; j < 8; j++) begin
            int s;
            int t;
            s = (p + j) % 8;
            t = int'(fi[s*2 +: 2]);
            if (n < 2 && r[s] && !blocked[t] && !(npm[t] && used[t])) begin
                g[s] = 1'b1;
                v[n] = 1'b1;
                ix[n*3 +: 3] = 3'(s);
                fn[n*2 +: 2] = 2'(t);
                if (npm[t]) used[t] = 1'b1;
                n++;
            end
        end
    endfunction

    task automatic model_reset();
        pm[0] = 0; pm[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int t = 0; t < 4; t++) rdy[i][t] = 0;
        gq0.delete(); gq1.delete(); iq0.delete(); iq1.delete();
        cur0 = '0; cur1 = '0;
    endtask

    task automatic step(input logic [7:0] r, input logic [15:0] fi, input logic st);
        @(negedge clock);
        req = r; func_in = fi; stall = st;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] blk;
            logic [7:0] g;
            logic [1:0] v;
            logic [5:0] ix;
            logic [3:0] fn;
            logic [2:0] last;
            for (int t = 0; t < 4; t++) blk[t] = npm[t] && (cyc < rdy[i][t]);
            pick(pm[i], r, fi, blk, g, v, ix, fn);
            if (i == 0) gq0.push_back(st ? 8'h00 : g);
            else        gq1.push_back(st ? 8'h00 : g);
            if (!st) begin
                if (i == 0) iq0.push_back({v, ix, fn});
                else        iq1.push_back({v, ix, fn});
                for (int k = 0; k < 2; k++)
                    if (v[k] && npm[fn[k*2 +: 2]]) rdy[i][fn[k*2 +: 2]] = cyc + 4;
                if (i == 1 && v != 2'b00) begin
                    last  = v[1] ? ix[5:3] : ix[2:0];
                    pm[1] = (int'(last) + 1) % 8;
                end
            end
        end
        cyc++;
    endtask

    // Combinational grant monitor
    always @(negedge clock) begin
        #2;
        if (mon_en) begin
            if (gq0.size() > 0) chk("gnt_fixed", {24'h0, gnt0}, {24'h0, gq0.pop_front()});
            if (gq1.size() > 0) chk("gnt_rr", {24'h0, gnt1}, {24'h0, gq1.pop_front()});
        end
    end

    // Registered issue-port monitor
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            if (iq0.size() > 0) cur0 = iq0.pop_front();
            if (iq1.size() > 0) cur1 = iq1.pop_front();
            chk("issue_fixed", {20'h0, iv0, ii0, if0}, {20'h0, cur0});
            chk("issue_rr", {20'h0, iv1, ii1, if1}, {20'h0, cur1});
        end
    end

    initial begin
        logic [7:0] rrx [5];
        rrx[0] = 8'h03; rrx[1] = 8'h0C; rrx[2] = 8'h30; rrx[3] = 8'hC0; rrx[4] = 8'h03;
        reset_n = 1'b0; req = '0; func_in = '0; stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        req = 8'hFF;
        #1;
        chk("rst_valid", {30'h0, iv0}, 32'h0);
        chk("rst_idx_func", {22'h0, ii0, if0}, 32'h0);
        chk("rst_gnt0", {24'h0, gnt0}, 32'h0);
        chk("rst_gnt1", {24'h0, gnt1}, 32'h0);
        req = '0;
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        step(8'b0110_0100, 16'h0000, 1'b0);
        chk("t1_gnt", {24'h0, gnt0}, 32'h24);
        step(8'b0000_1000, 16'h0000, 1'b0);
        chk("t1_valid", {30'h0, iv0}, 32'h3);
        chk("t1_idx", {26'h0, ii0}, {26'h0, 3'd5, 3'd2});
        chk("t2_gnt", {24'h0, gnt0}, 32'h08);
        step(8'h00, 16'h0000, 1'b0);
        chk("t2_valid", {30'h0, iv0}, 32'h1);
        chk("t2_idx0", {29'h0, ii0[2:0]}, 32'd3);
        chk("t2_port1", {27'h0, ii0[5:3], if0[3:2]}, 32'h0);

        step(8'h12, 16'h030C, 1'b0);
        chk("t3_first", {24'h0, gnt0}, 32'h02);
        for (int c = 0; c < 3; c++) begin
            step(8'h10, 16'h030C, 1'b0);
            chk("t3_blocked", {24'h0, gnt0}, 32'h00);
        end
        step(8'h10, 16'h030C, 1'b0);
        chk("t3_regrant", {24'h0, gnt0}, 32'h10);

        for (int c = 0; c < 3; c++) begin
            step(8'hFF, 16'h0000, 1'b1);
            chk("t4_stall_gnt", {24'h0, gnt0}, 32'h00);
            chk("t4_hold", {27'h0, iv0, ii0[2:0]}, {27'h0, 2'b01, 3'd4});
        end
        step(8'hFF, 16'h0000, 1'b0);
        chk("t4_unstall", {24'h0, gnt0}, 32'h03);

        step(8'hFF, 16'h0003, 1'b0);
        chk("t6_np_grant", {24'h0, gnt0}, 32'h03);
        step(8'hFF, 16'h0000, 1'b0);
        @(posedge clock);
        #2;
        mon_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", {28'h0, iv0, iv1}, 32'h0);
        chk("t6_async_idx", {20'h0, ii0, ii1}, 32'h0);
        chk("t6_async_func", {24'h0, if0, if1}, 32'h0);
        chk("t6_async_gnt", {16'h0, gnt0, gnt1}, 32'h0);
        req = '0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(8'h80, 16'hC000, 1'b0);
        chk("t6_np_free", {24'h0, gnt0}, 32'h80);

        for (int c = 0; c < 5; c++) begin
            step(8'hFF, 16'h0000, 1'b0);
            chk("t5_rr_pair", {24'h0, gnt1}, {24'h0, rrx[c]});
        end

        repeat (300) begin
            step(8'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0));
        end
        step(8'h00, 16'h0000, 1'b0);
        @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
